// File: rtl/wavetable_pkg.sv
// Shared wavetable definitions: RAM geometry, entry byte order and loader states.
// Also used by the wavetable RAM and the oscillator read path.
package wavetable_pkg;

  localparam int WT_RAM_SIZE = 61;
  localparam int WT_ADDR_W   = 6;

  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_FACTOR = 2;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_GET_L = 3'd1,
    LD_GET_R = 3'd2,
    LD_GET_F = 3'd3,
    LD_WRITE = 3'd4,
    LD_DONE  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/wavetable_loader.sv
// Write-side master for the wavetable RAM: packs the parser byte stream into
// 24-bit entries and writes them to consecutive addresses, yielding to reads.
//
// state    | meaning
// IDLE     | waiting for a start request
// GET_L    | accepting the left waveform byte
// GET_R    | accepting the right waveform byte
// GET_F    | accepting the factor byte
// WRITE    | holding we until a cycle without a read collision
// DONE     | one-cycle completion pulse
module wavetable_loader
  import wavetable_pkg::*;
#(
  parameter int RAM_SIZE = WT_RAM_SIZE,
  parameter int ADDR_W   = WT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              re_busy,
  output logic              we,
  output logic [ADDR_W-1:0] addr_w,
  output logic [7:0]        waveform_left_w,
  output logic [7:0]        waveform_right_w,
  output logic [7:0]        factor_w,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]   SIZE_C = (ADDR_W+1)'(RAM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(RAM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE_C  = ADDR_W'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [7:0]        byte_q [3];
  logic [7:0]        byte_d [3];
  logic              error_q, error_d;

  logic accept;
  logic commit;
  logic start_ok;

  assign accept   = in_valid && in_ready;
  // The RAM read port wins any same-cycle collision, so only a read-free cycle commits.
  assign commit   = (state_q == LD_WRITE) && !re_busy;
  assign start_ok = (count != '0) && ({1'b0, count} <= SIZE_C) &&
                    ({1'b0, start_addr} < SIZE_C);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    byte_d   = byte_q;
    error_d  = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d  = LD_GET_L;
            addr_d   = start_addr;
            remain_d = count;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LD_GET_L: begin
        if (accept) begin
          byte_d[IDX_LEFT] = in_data;
          state_d          = LD_GET_R;
        end
      end
      LD_GET_R: begin
        if (accept) begin
          byte_d[IDX_RIGHT] = in_data;
          state_d           = LD_GET_F;
        end
      end
      LD_GET_F: begin
        if (accept) begin
          byte_d[IDX_FACTOR] = in_data;
          state_d            = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (commit) begin
          remain_d = remain_q - ONE_C;
          addr_d   = (addr_q == LAST_C) ? '0 : addr_q + ONE_C;
          state_d  = (remain_q > ONE_C) ? LD_GET_L : LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LD_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      byte_q   <= '{default: 8'h00};
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      byte_q   <= byte_d;
      error_q  <= error_d;
    end
  end

  assign in_ready         = (state_q == LD_GET_L) || (state_q == LD_GET_R) ||
                            (state_q == LD_GET_F);
  assign we               = (state_q == LD_WRITE);
  assign busy             = (state_q != LD_IDLE);
  assign done             = (state_q == LD_DONE);
  assign error            = error_q;
  assign addr_w           = addr_q;
  assign waveform_left_w  = byte_q[IDX_LEFT];
  assign waveform_right_w = byte_q[IDX_RIGHT];
  assign factor_w         = byte_q[IDX_FACTOR];

endmodule

// File: tb/tb_wavetable_loader.sv
// Scenario bench for wavetable_loader: expected writes are queued as bytes are
// driven and matched against every committed write seen on the RAM port.
module tb_wavetable_loader;
  import wavetable_pkg::*;

  localparam int AW = WT_ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] count = '0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          re_busy = 1'b0;
  logic          in_ready, we, busy, done, error;
  logic [AW-1:0] addr_w;
  logic [7:0]    wl, wr, wf;

  wavetable_loader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .re_busy(re_busy),
    .we(we), .addr_w(addr_w), .waveform_left_w(wl), .waveform_right_w(wr),
    .factor_w(wf), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [23:0] ram [WT_RAM_SIZE];
  int errors = 0, checks = 0, cyc = 0;
  int commits = 0, we_cycles = 0, last_commit_cyc = -100, commit_gap = 0, done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM-port monitor: a write commits at the next rising edge when we && !re_busy
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst) begin
      if (we) we_cycles++;
      if (done) done_cyc = cyc;
      if (we && !re_busy) begin
        commits++;
        commit_gap = cyc - last_commit_cyc;
        last_commit_cyc = cyc;
        if (int'(addr_w) < WT_RAM_SIZE) ram[addr_w] = {wf, wr, wl};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h", addr_w, {wf, wr, wl});
        end else begin
          e = exp_q.pop_front();
          if (addr_w !== e.addr || {wf, wr, wl} !== e.data) begin
            errors++;
            $display("FAIL write_match got addr=%0d data=%h expected addr=%0d data=%h",
                     addr_w, {wf, wr, wl}, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] c);
    start_addr = a; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout byte=%h in_ready=%b expected 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_entry(input logic [AW-1:0] a, input logic [7:0] l, r, f);
    exp_q.push_back({a, f, r, l});
    send_byte(l); send_byte(r); send_byte(f);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout done=%b expected 1", done);
    end else if (!busy) begin
      errors++;
      $display("FAIL busy_during_done busy=%b expected 1", busy);
    end
    #1;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes left=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, we, busy, done, error, addr_w, wl, wr, wf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ir=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h expected all 0",
               in_ready, we, busy, done, error, addr_w, {wf, wr, wl});
    end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    pulse_start(6'd0, 6'd2);
    checks++;
    if (busy !== 1'b1 || addr_w !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_start busy=%b addr=%0d ir=%b expected 1/0/1", busy, addr_w, in_ready);
    end
    send_entry(6'd0, 8'h11, 8'h22, 8'h33);
    send_entry(6'd1, 8'h44, 8'h55, 8'h66);
    wait_done();
    checks++;
    if (done_cyc != last_commit_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_latency done_cyc=%0d expected %0d", done_cyc, last_commit_cyc + 1);
    end
    checks++;
    if (commit_gap != 4) begin
      errors++;
      $display("FAIL basic_throughput gap=%0d expected 4", commit_gap);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done done=%b busy=%b expected 0/0", done, busy);
    end
    checks++;
    if (ram[0] !== 24'h332211 || ram[1] !== 24'h665544) begin
      errors++;
      $display("FAIL basic_ram got %h %h expected 332211 665544", ram[0], ram[1]);
    end
    check_queue_empty("basic");
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    pulse_start(6'd60, 6'd2);
    send_entry(6'd60, 8'h71, 8'h72, 8'h73);
    send_entry(6'd0, 8'h81, 8'h82, 8'h83);
    wait_done();
    checks++;
    if (ram[60] !== 24'h737271 || ram[0] !== 24'h838281 || ram[1] !== 24'h665544) begin
      errors++;
      $display("FAIL wrap_ram got 60=%h 0=%h 1=%h expected 737271 838281 665544",
               ram[60], ram[0], ram[1]);
    end
    check_queue_empty("wrap");
    tick();
  endtask

  task automatic test_read_collision();
    int w0, c0;
    w0 = we_cycles; c0 = commits;
    pulse_start(6'd10, 6'd1);
    exp_q.push_back({6'd10, 24'h9C9B9A});
    send_byte(8'h9A); send_byte(8'h9B); send_byte(8'h9C);
    re_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (we !== 1'b1 || addr_w !== 6'd10 || {wf, wr, wl} !== 24'h9C9B9A) begin
        errors++;
        $display("FAIL collision_hold cycle=%0d we=%b addr=%0d data=%h expected 1/10/9c9b9a",
                 i, we, addr_w, {wf, wr, wl});
      end
      @(posedge clk); #1;
    end
    re_busy = 1'b0;
    wait_done();
    checks++;
    if (we_cycles - w0 != 4 || commits - c0 != 1) begin
      errors++;
      $display("FAIL collision_counts we_cycles=%0d commits=%0d expected 4 and 1",
               we_cycles - w0, commits - c0);
    end
    checks++;
    if (ram[10] !== 24'h9C9B9A) begin
      errors++;
      $display("FAIL collision_ram got %h expected 9c9b9a", ram[10]);
    end
    check_queue_empty("collision");
    tick();
  endtask

  task automatic test_stalled_stream();
    logic [7:0] d [6];
    logic       v [6];
    d = '{8'hA1, 8'hEE, 8'hEE, 8'hB2, 8'hEE, 8'hC3};
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pulse_start(6'd20, 6'd1);
    exp_q.push_back({6'd20, 24'hC3B2A1});
    for (int i = 0; i < 6; i++) begin
      in_data = d[i]; in_valid = v[i];
      tick();
    end
    in_valid = 1'b0;
    wait_done();
    checks++;
    if (ram[20] !== 24'hC3B2A1) begin
      errors++;
      $display("FAIL stall_ram got %h expected c3b2a1", ram[20]);
    end
    check_queue_empty("stall");
    tick();
  endtask

  task automatic test_rejection();
    logic [AW-1:0] ra [3];
    logic [AW-1:0] rc [3];
    int c0;
    ra = '{6'd0, 6'd61, 6'd0};
    rc = '{6'd0, 6'd1, 6'd62};
    for (int i = 0; i < 3; i++) begin
      pulse_start(ra[i], rc[i]);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reject_%0d error=%b busy=%b expected 1/0", i, error, busy);
      end
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse_%0d error=%b busy=%b expected 0/0", i, error, busy);
      end
    end
    c0 = commits;
    pulse_start(6'd5, 6'd1);
    exp_q.push_back({6'd5, 24'hD3D2D1});
    send_byte(8'hD1);
    pulse_start(6'd30, 6'd2);
    checks++;
    if (error !== 1'b0 || addr_w !== 6'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_ignored error=%b addr=%0d busy=%b expected 0/5/1", error, addr_w, busy);
    end
    send_byte(8'hD2); send_byte(8'hD3);
    wait_done();
    checks++;
    if (commits - c0 != 1 || ram[5] !== 24'hD3D2D1) begin
      errors++;
      $display("FAIL busy_start_load commits=%0d ram5=%h expected 1 and d3d2d1", commits - c0, ram[5]);
    end
    check_queue_empty("reject");
    tick();
  endtask

  task automatic test_reset_mid_load();
    int c0;
    pulse_start(6'd40, 6'd3);
    send_entry(6'd40, 8'hE1, 8'hE2, 8'hE3);
    send_byte(8'hF1); send_byte(8'hF2);
    c0 = commits;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, we, busy, done, error, addr_w, wl, wr, wf} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs ir=%b we=%b busy=%b addr=%0d data=%h expected all 0",
               in_ready, we, busy, addr_w, {wf, wr, wl});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h50 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (commits != c0 || busy !== 1'b0 || ram[40] !== 24'hE3E2E1) begin
      errors++;
      $display("FAIL midreset_after commits=%0d busy=%b ram40=%h expected %0d/0/e3e2e1",
               commits, busy, ram[40], c0);
    end
    check_queue_empty("midreset");
  endtask

  initial begin
    for (int i = 0; i < WT_RAM_SIZE; i++) ram[i] = 24'hA5A5A5;
    test_reset();
    test_basic_load();
    test_wrap();
    test_read_collision();
    test_stalled_stream();
    test_rejection();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/wavetable_loader.md
Name: wavetable_loader

Overview:
- Write-side master for the wavetable RAM. It sits between the byte stream from the SysEx/patch parser and the RAM write port.
- It packs incoming bytes into 24-bit entries in the order left waveform, right waveform, factor, and writes them to consecutive RAM addresses.
- The RAM gives its read port priority, so the loader detects a read in the same cycle and retries the write. The oscillator read path is never stalled.

Parameters:
- RAM_SIZE, 61, number of wavetable entries; valid addresses are 0..RAM_SIZE-1.
- ADDR_W, 6, address width; must satisfy 2^ADDR_W >= RAM_SIZE.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
- start_addr  in  ADDR_W  first entry address to write.
- count  in  ADDR_W  number of entries to write (1..RAM_SIZE).
- in_data  in  8  byte stream data.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- re_busy  in  1  the RAM read port's re for this cycle; a write is lost when it is high.
- we  out  1  RAM write enable.
- addr_w  out  ADDR_W  RAM write address.
- waveform_left_w  out  8  entry byte 0.
- waveform_right_w  out  8  entry byte 1.
- factor_w  out  8  entry byte 2.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last entry has been committed.
- error  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: in_ready, we, addr_w, the data bytes, busy, done, error.
  - The internal address and remaining-entry counters clear.
- Start request in IDLE:
  - If count==0 or count>RAM_SIZE or start_addr>=RAM_SIZE, pulse error the next cycle and stay in IDLE.
  - Otherwise, on the next cycle: state=GET_L, busy=1, addr_w=start_addr, remaining=count.
- FSM states: IDLE, GET_L, GET_R, GET_F, WRITE, DONE.
- GET_L, GET_R, GET_F:
  - in_ready=1 in these states only.
  - A byte transfers when in_valid && in_ready. It loads the matching data register and advances GET_L->GET_R->GET_F->WRITE.
  - With in_valid low, the FSM holds state; there is no timeout.
- WRITE:
  - in_ready=0 and we=1; data and addr_w are held stable.
  - The write is committed in a cycle where we=1 and re_busy=0.
  - If re_busy=1, the write is not committed and the FSM stays in WRITE, retrying every cycle until a cycle with re_busy=0.
  - On commit:
    - remaining is decremented.
    - addr_w advances by 1 and wraps from RAM_SIZE-1 to 0.
    - Next state is GET_L if the remaining count before decrement was >1, else DONE.
  - we deasserts in the cycle after commit.
- DONE: done=1 for exactly one cycle, busy=0 from the following cycle, then return to IDLE.
- Throughput with no read collisions: 4 cycles per entry (3 byte cycles plus 1 write).
- A start pulse while busy=1 is ignored, with no error pulse.
- If rst asserts mid-load, the load is aborted immediately and the partial entry is discarded. Entries already committed remain in the RAM.
- Data bytes keep their last value in IDLE. Only we qualifies them.

Decomposition:
- Shared package wavetable_pkg holds:
  - WT_RAM_SIZE=61 and WT_ADDR_W=6, also used by the RAM and the reader.
  - The loader state enum.
  - The entry byte-order constants: IDX_LEFT=0, IDX_RIGHT=1, IDX_FACTOR=2.
- No sub-module is needed. The FSM, counters and byte registers form one module.

Test Plan:
- Basic load:
  - Stimulus: start_addr=0, count=2, bytes 11,22,33,44,55,66 streamed back-to-back, re_busy=0.
  - Response: we pulses at addr 0 with {33,22,11} and at addr 1 with {66,55,44}; done pulses 1 cycle after the second commit; reading addresses 0 and 1 afterwards returns the same values.
- Wrap-around:
  - Stimulus: start_addr=60, count=2.
  - Response: writes go to addr 60 then addr 0; address 1 is untouched.
- Read collision:
  - Stimulus: re_busy held 1 for 3 cycles while in WRITE.
  - Response: we stays high for 4 cycles with addr and data unchanged; exactly one commit; RAM content correct.
- Stalled stream:
  - Stimulus: in_valid toggled 1,0,0,1,0,1 through an entry.
  - Response: only valid cycles are consumed; the entry is written with the correct byte order.
- Rejection:
  - Stimulus: start with count=0, then start_addr=61; also a start pulse during a load.
  - Response: error pulses for the first two with busy staying 0; the start during a load is ignored and that load completes normally.
- Reset mid-load:
  - Stimulus: assert rst after 2 bytes of entry 1 of count=3.
  - Response: outputs go to 0 immediately; entry 0 retained; no further writes.
